// File: rtl/chacha_pkg.sv
// Shared types and helpers for the ChaCha20-Poly1305 block formatter: state encoding and byte-enable utilities.
package chacha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AAD  = 3'd1,
        ST_PLD  = 3'd2,
        ST_LEN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [15:0] KEEP_FULL = 16'hFFFF;

    function automatic logic [4:0] keep_popcount(input logic [15:0] keep);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'd0, keep[i]};
        return n;
    endfunction

    // Contiguous from bit 0 means keep+1 is a power of two (or wraps to zero).
    function automatic logic keep_contiguous(input logic [15:0] keep);
        logic [15:0] p1;
        p1 = keep + 16'd1;
        return (keep & p1) == 16'd0;
    endfunction

    function automatic logic [127:0] keep_byte_mask(input logic [15:0] keep);
        logic [127:0] m;
        for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{keep[i]}};
        return m;
    endfunction

endpackage

// File: rtl/chacha_poly_blk_fmt.sv
// Splits an AAD/payload beat stream into zero-padded 16-byte Poly1305 blocks plus a final length block.
// One cycle input-to-output latency; in_ready drops while the phase's output register is full and not draining.
module chacha_poly_blk_fmt
    import chacha_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [15:0]  in_keep,
    input  logic         in_sel,
    input  logic         in_last,
    output logic         aad_valid,
    input  logic         aad_ready,
    output logic [127:0] aad_data,
    output logic [15:0]  aad_keep,
    output logic         pld_valid,
    input  logic         pld_ready,
    output logic [127:0] pld_data,
    output logic [15:0]  pld_keep,
    output logic         len_valid,
    input  logic         len_ready,
    output logic [127:0] len_block,
    output logic [63:0]  aad_bytes,
    output logic [63:0]  pld_bytes,
    output logic         busy,
    output logic         done,
    output logic         proto_err
);

    state_t         r_state;
    logic           r_aad_vld, r_pld_vld, r_len_vld;
    logic [127:0]   r_aad_dat, r_pld_dat, r_len_blk;
    logic [15:0]    r_aad_keep, r_pld_keep;
    logic [63:0]    r_aad_cnt, r_pld_cnt;
    logic           r_err;
    logic           r_seg_end;

    logic           w_aad_free, w_pld_free, w_in_rdy;
    logic           w_acc, w_bad, w_good, w_fwd, w_drained;
    logic [127:0]   w_dat;
    logic [63:0]    w_cnt_inc;

    assign w_aad_free = !r_aad_vld || aad_ready;
    assign w_pld_free = !r_pld_vld || pld_ready;
    // r_seg_end blocks further payload while the last block drains before LEN.
    assign w_in_rdy   = (r_state == ST_AAD && !in_sel && w_aad_free) ||
                        (r_state == ST_PLD &&  in_sel && !r_seg_end && w_pld_free);
    assign w_acc      = in_valid && w_in_rdy;
    assign w_bad      = !keep_contiguous(in_keep) || (!in_last && in_keep != KEEP_FULL);
    assign w_good     = w_acc && !w_bad;
    assign w_fwd      = w_good && (in_keep != 16'd0);
    assign w_dat      = in_data & keep_byte_mask(in_keep);
    assign w_cnt_inc  = {59'd0, keep_popcount(in_keep)};
    assign w_drained  = w_aad_free && w_pld_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_aad_vld  <= 1'b0;
            r_pld_vld  <= 1'b0;
            r_len_vld  <= 1'b0;
            r_aad_dat  <= '0;
            r_pld_dat  <= '0;
            r_len_blk  <= '0;
            r_aad_keep <= '0;
            r_pld_keep <= '0;
            r_aad_cnt  <= '0;
            r_pld_cnt  <= '0;
            r_err      <= 1'b0;
            r_seg_end  <= 1'b0;
        end else begin
            if (r_aad_vld && aad_ready) r_aad_vld <= 1'b0;
            if (r_pld_vld && pld_ready) r_pld_vld <= 1'b0;
            if (w_acc && w_bad)         r_err     <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_aad_cnt <= '0;
                        r_pld_cnt <= '0;
                        r_seg_end <= 1'b0;
                        r_state   <= ST_AAD;
                    end
                end
                ST_AAD: begin
                    if (w_good) begin
                        r_aad_cnt <= r_aad_cnt + w_cnt_inc;
                        if (w_fwd) begin
                            r_aad_vld  <= 1'b1;
                            r_aad_dat  <= w_dat;
                            r_aad_keep <= KEEP_FULL;
                        end
                        if (in_last) r_state <= ST_PLD;
                    end
                end
                ST_PLD: begin
                    if (r_seg_end) begin
                        if (w_drained) begin
                            r_len_vld <= 1'b1;
                            r_len_blk <= {r_pld_cnt, r_aad_cnt};
                            r_seg_end <= 1'b0;
                            r_state   <= ST_LEN;
                        end
                    end else if (w_good) begin
                        r_pld_cnt <= r_pld_cnt + w_cnt_inc;
                        if (w_fwd) begin
                            r_pld_vld  <= 1'b1;
                            r_pld_dat  <= w_dat;
                            r_pld_keep <= KEEP_FULL;
                        end
                        if (in_last) r_seg_end <= 1'b1;
                    end
                end
                ST_LEN: begin
                    if (len_ready) begin
                        r_len_vld <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_rdy;
    assign aad_valid = r_aad_vld;
    assign aad_data  = r_aad_dat;
    assign aad_keep  = r_aad_keep;
    assign pld_valid = r_pld_vld;
    assign pld_data  = r_pld_dat;
    assign pld_keep  = r_pld_keep;
    assign len_valid = r_len_vld;
    assign len_block = r_len_blk;
    assign aad_bytes = r_aad_cnt;
    assign pld_bytes = r_pld_cnt;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign proto_err = r_err;

endmodule

// File: tb/tb_chacha_poly_blk_fmt.sv
// Randomized bench for chacha_poly_blk_fmt against a queue-based block/length model.
module tb_chacha_poly_blk_fmt;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic         in_valid = 1'b0, in_sel = 1'b0, in_last = 1'b0;
    logic [127:0] in_data = '0;
    logic [15:0]  in_keep = '0;
    logic         in_ready;
    logic         aad_valid, aad_ready = 1'b0;
    logic [127:0] aad_data;
    logic [15:0]  aad_keep;
    logic         pld_valid, pld_ready = 1'b0;
    logic [127:0] pld_data;
    logic [15:0]  pld_keep;
    logic         len_valid, len_ready = 1'b0;
    logic [127:0] len_block;
    logic [63:0]  aad_bytes, pld_bytes;
    logic         busy, done, proto_err;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    chacha_poly_blk_fmt dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_sel(in_sel), .in_last(in_last),
        .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_data(aad_data), .aad_keep(aad_keep),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data), .pld_keep(pld_keep),
        .len_valid(len_valid), .len_ready(len_ready), .len_block(len_block),
        .aad_bytes(aad_bytes), .pld_bytes(pld_bytes),
        .busy(busy), .done(done), .proto_err(proto_err)
    );

    typedef struct {
        bit           sel;
        logic [127:0] data;
        logic [15:0]  keep;
        bit           last;
    } beat_t;

    beat_t        msg[$];
    logic [127:0] exp_aad[$], exp_pld[$];
    logic [63:0]  m_aad = '0, m_pld = '0;
    bit           m_err = 1'b0;
    logic [127:0] exp_len = '0;
    int           n_aad_hs = 0, n_pld_hs = 0, n_len_hs = 0;
    logic [127:0] last_aad = '0, last_len = '0;
    bit           hold_pld = 1'b0;

    task automatic chkb(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int popcnt(input logic [15:0] k);
        int n = 0;
        for (int i = 0; i < 16; i++) if (k[i]) n++;
        return n;
    endfunction

    function automatic logic [127:0] mask_bytes(input logic [127:0] d, input logic [15:0] k);
        logic [127:0] r = d;
        for (int i = 0; i < 16; i++) if (!k[i]) r[8*i +: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [15:0] keep_of_len(input int n);
        logic [31:0] t = (32'd1 << n) - 32'd1;
        return t[15:0];
    endfunction

    // A beat is legal when its keep is the first n bytes, and only a last beat may be short.
    function automatic bit keep_ok(input logic [15:0] k, input bit last);
        int n = popcnt(k);
        if (k != keep_of_len(n)) return 1'b0;
        return last || (n == 16);
    endfunction

    function automatic void add(input bit sel, input logic [127:0] d, input logic [15:0] k, input bit last);
        beat_t b;
        b.sel = sel; b.data = d; b.keep = k; b.last = last;
        msg.push_back(b);
    endfunction

    task automatic model_msg();
        exp_aad.delete();
        exp_pld.delete();
        m_aad = '0;
        m_pld = '0;
        foreach (msg[i]) begin
            if (!keep_ok(msg[i].keep, msg[i].last)) begin
                m_err = 1'b1;
            end else if (msg[i].sel) begin
                m_pld = m_pld + 64'(popcnt(msg[i].keep));
                if (msg[i].keep != 16'd0) exp_pld.push_back(mask_bytes(msg[i].data, msg[i].keep));
            end else begin
                m_aad = m_aad + 64'(popcnt(msg[i].keep));
                if (msg[i].keep != 16'd0) exp_aad.push_back(mask_bytes(msg[i].data, msg[i].keep));
            end
        end
        exp_len  = {m_pld, m_aad};
        n_aad_hs = 0;
        n_pld_hs = 0;
        n_len_hs = 0;
    endtask

    // Downstream ready generator: random unless the payload sink is being held off.
    initial forever begin
        @(posedge clk);
        #1;
        aad_ready = ($urandom_range(0, 3) != 0);
        pld_ready = hold_pld ? 1'b0 : ($urandom_range(0, 3) != 0);
        len_ready = ($urandom_range(0, 1) != 0);
    end

    task automatic set_hold_pld(input bit b);
        hold_pld = b;
        if (b) pld_ready = 1'b0;
    endtask

    // Output monitor: every handshake is matched against the model, pending outputs must stay stable.
    bit           aad_hold = 1'b0, pld_hold = 1'b0, done_exp = 1'b0;
    logic [127:0] prev_aad = '0, prev_pld = '0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            aad_hold = 1'b0;
            pld_hold = 1'b0;
            done_exp = 1'b0;
        end else begin
            chkb("done_pulse", done, done_exp);
            done_exp = 1'b0;
            if (aad_valid) begin
                if (aad_hold) chkw("aad_stable", aad_data, prev_aad);
                chkw("aad_keep", {112'd0, aad_keep}, {112'd0, 16'hFFFF});
                if (aad_ready) begin
                    n_aad_hs++;
                    last_aad = aad_data;
                    chkb("aad_block_expected", exp_aad.size() != 0, 1'b1);
                    if (exp_aad.size() != 0) chkw("aad_data", aad_data, exp_aad.pop_front());
                end
            end
            aad_hold = aad_valid && !aad_ready;
            prev_aad = aad_data;
            if (pld_valid) begin
                if (pld_hold) chkw("pld_stable", pld_data, prev_pld);
                chkw("pld_keep", {112'd0, pld_keep}, {112'd0, 16'hFFFF});
                if (pld_ready) begin
                    n_pld_hs++;
                    chkb("pld_block_expected", exp_pld.size() != 0, 1'b1);
                    if (exp_pld.size() != 0) chkw("pld_data", pld_data, exp_pld.pop_front());
                end
            end
            pld_hold = pld_valid && !pld_ready;
            prev_pld = pld_data;
            if (len_valid && len_ready) begin
                n_len_hs++;
                last_len = len_block;
                chkw("len_block", len_block, exp_len);
                done_exp = 1'b1;
            end
        end
    end

    // All driver tasks are entered just after a rising edge and return just after one.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input beat_t b);
        int n = 0;
        in_valid = 1'b1; in_sel = b.sel; in_data = b.data; in_keep = b.keep; in_last = b.last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                chkb("in_ready_timeout", in_ready, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (keep_ok(b.keep, b.last) && b.keep != 16'd0) begin
            @(negedge clk);
            if (b.sel) begin
                chkb("pld_latency_vld", pld_valid, 1'b1);
                chkw("pld_latency_dat", pld_data, mask_bytes(b.data, b.keep));
            end else begin
                chkb("aad_latency_vld", aad_valid, 1'b1);
                chkw("aad_latency_dat", aad_data, mask_bytes(b.data, b.keep));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_msg();
        int n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 500) begin
                chkb("done_timeout", done, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        chkb("busy_idle", busy, 1'b0);
        chkw("aad_bytes", {64'd0, aad_bytes}, {64'd0, m_aad});
        chkw("pld_bytes", {64'd0, pld_bytes}, {64'd0, m_pld});
        chkb("proto_err", proto_err, m_err);
        chkw("blocks_left", 128'(exp_aad.size() + exp_pld.size()), 128'd0);
        chkw("len_handshakes", 128'(n_len_hs), 128'd1);
    endtask

    task automatic run_msg();
        model_msg();
        do_start();
        chkb("busy_after_start", busy, 1'b1);
        foreach (msg[i]) send_beat(msg[i]);
        finish_msg();
    endtask

    task automatic chk_all_zero(input string tag);
        chkw({tag, "_ctl"}, {120'd0, in_ready, aad_valid, pld_valid, len_valid, busy, done, proto_err, 1'b0}, 128'd0);
        chkw({tag, "_aad"}, aad_data, 128'd0);
        chkw({tag, "_pld"}, pld_data, 128'd0);
        chkw({tag, "_keeps"}, {96'd0, aad_keep, pld_keep}, 128'd0);
        chkw({tag, "_len"}, len_block, 128'd0);
        chkw({tag, "_cnt"}, {aad_bytes, pld_bytes}, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        beat_t b;
        logic [127:0] d1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RFC 8439 2.8.2 shape: 12-byte AAD, 114-byte payload.
        msg.delete();
        add(0, {128{1'b1}}, 16'h0FFF, 1);
        for (int i = 0; i < 7; i++) add(1, rnd128(), 16'hFFFF, 0);
        add(1, rnd128(), 16'h0003, 1);
        run_msg();
        chkw("rfc_aad_pad", last_aad, {32'd0, {96{1'b1}}});
        chkw("rfc_pld_blocks", 128'(n_pld_hs), 128'd8);
        chkw("rfc_len", last_len, {64'd114, 64'd12});
        chkw("rfc_counts", {aad_bytes, pld_bytes}, {64'd12, 64'd114});

        // Empty AAD segment.
        msg.delete();
        add(0, rnd128(), 16'h0000, 1);
        add(1, rnd128(), 16'hFFFF, 1);
        run_msg();
        chkw("empty_aad_blocks", 128'(n_aad_hs), 128'd0);
        chkw("empty_pld_blocks", 128'(n_pld_hs), 128'd1);
        chkw("empty_len", last_len, {64'd16, 64'd0});

        // Payload sink stalled for 5 cycles with a second beat offered.
        msg.delete();
        d1 = rnd128();
        add(0, rnd128(), 16'hFFFF, 1);
        add(1, d1, 16'hFFFF, 0);
        add(1, rnd128(), 16'hFFFF, 0);
        add(1, rnd128(), 16'h00FF, 1);
        model_msg();
        set_hold_pld(1);
        do_start();
        send_beat(msg[0]);
        send_beat(msg[1]);
        in_valid = 1'b1; in_sel = 1'b1; in_data = msg[2].data; in_keep = msg[2].keep; in_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chkb("stall_in_ready", in_ready, 1'b0);
            chkb("stall_pld_valid", pld_valid, 1'b1);
            chkw("stall_pld_data", pld_data, d1);
        end
        set_hold_pld(0);
        @(posedge clk);
        #1;
        send_beat(msg[2]);
        send_beat(msg[3]);
        finish_msg();
        chkw("stall_pld_bytes", {64'd0, pld_bytes}, 128'd40);

        // Payload beat offered during AAD must stall; a stray start mid-message is ignored.
        msg.delete();
        add(0, rnd128(), 16'hFFFF, 0);
        add(0, rnd128(), 16'h001F, 1);
        add(1, rnd128(), 16'hFFFF, 1);
        model_msg();
        do_start();
        send_beat(msg[0]);
        do_start();
        in_valid = 1'b1; in_sel = 1'b1; in_data = msg[2].data; in_keep = msg[2].keep; in_last = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chkb("sel_stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        send_beat(msg[1]);
        send_beat(msg[2]);
        finish_msg();
        chkw("sel_counts", {aad_bytes, pld_bytes}, {64'd21, 64'd16});

        // Randomized legal messages.
        for (int m = 0; m < 8; m++) begin
            msg.delete();
            for (int s = 0; s < 2; s++) begin
                int nb = (s == 0) ? $urandom_range(0, 3) : $urandom_range(0, 4);
                if (nb == 0) begin
                    add(s[0], rnd128(), 16'h0000, 1);
                end else begin
                    for (int k = 0; k < nb - 1; k++) add(s[0], rnd128(), 16'hFFFF, 0);
                    add(s[0], rnd128(), keep_of_len($urandom_range(0, 16)), 1);
                end
            end
            run_msg();
        end

        // Short non-last payload beat: flagged and dropped, flag is sticky.
        msg.delete();
        add(0, rnd128(), 16'h0000, 1);
        add(1, rnd128(), 16'h00FF, 0);
        add(1, rnd128(), 16'hFFFF, 1);
        run_msg();
        chkb("bad_beat_err", proto_err, 1'b1);
        chkw("bad_beat_bytes", {64'd0, pld_bytes}, 128'd16);
        msg.delete();
        add(0, rnd128(), 16'hFFFF, 1);
        add(1, rnd128(), 16'h0FFF, 1);
        run_msg();
        chkb("err_sticky", proto_err, 1'b1);

        // Reset with a payload block pending.
        msg.delete();
        add(0, rnd128(), 16'hFFFF, 1);
        add(1, rnd128(), 16'hFFFF, 0);
        model_msg();
        set_hold_pld(1);
        do_start();
        send_beat(msg[0]);
        send_beat(msg[1]);
        @(negedge clk);
        chkb("pre_reset_pld_valid", pld_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("mid_reset");
        rst_n = 1'b1;
        m_err = 1'b0;
        exp_aad.delete();
        exp_pld.delete();
        set_hold_pld(0);
        repeat (3) begin
            @(negedge clk);
            chkb("post_reset_no_pld", pld_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        msg.delete();
        add(0, rnd128(), 16'h0007, 1);
        add(1, rnd128(), 16'hFFFF, 0);
        add(1, rnd128(), 16'h7FFF, 1);
        run_msg();
        chkw("clean_len", last_len, {64'd31, 64'd3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
